// File: rtl/imem_loader_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned DEF_REG_BITS  = 32;
  localparam int unsigned DEF_ADDR_BITS = 8;
  localparam int unsigned DEF_CNT_BITS  = 8;
  localparam int unsigned BPW           = DEF_REG_BITS / 8;
  localparam int unsigned MEM_DEPTH     = 2 ** DEF_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a byte index over a word of nbytes bytes (at least 1 bit).
  function automatic int unsigned idx_bits(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_word_serializer.sv
// Holds one instruction word and presents it MSB byte first, one byte per shift.
module word_serializer
  import imem_loader_pkg::*;
#(
  parameter int unsigned REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [REG_BITS-1:0] word,
  output logic [7:0]          byte_out,
  output logic                last
);

  localparam int unsigned NBYTES = REG_BITS / 8;
  localparam int unsigned IDX_W  = idx_bits(NBYTES);

  logic [REG_BITS-1:0] shift_q;
  logic [IDX_W-1:0]    idx_q;

  // Load has priority; shifting moves the next byte into the top lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      idx_q   <= '0;
    end else if (shift) begin
      shift_q <= {shift_q[REG_BITS-9:0], 8'h00};
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

  assign byte_out = shift_q[REG_BITS-1 -: 8];
  assign last     = (idx_q == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into the byte-wide instruction memory, big-endian,
// at consecutive byte addresses from a programmable base.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned REG_BITS  = DEF_REG_BITS,
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned CNT_BITS  = DEF_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  word_count,
  input  logic                 in_valid,
  input  logic [REG_BITS-1:0]  in_word,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap_err
);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_BITS-1:0]  words_left_q, words_left_d;
  logic                 wrap_d;
  logic                 load, shift, last;
  logic [7:0]           ser_byte;

  word_serializer #(.REG_BITS(REG_BITS)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .word     (in_word),
    .byte_out (ser_byte),
    .last     (last)
  );

  // Next state, address/count generation and serializer control.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    wrap_d       = wrap_err;
    load         = 1'b0;
    shift        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d       = base_addr;
          words_left_d = word_count;
          wrap_d       = 1'b0;
          state_d      = (word_count == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        shift  = 1'b1;
        addr_d = addr_q + ADDR_BITS'(1);
        if (addr_q == '1) wrap_d = 1'b1;
        if (last) begin
          words_left_d = words_left_q - CNT_BITS'(1);
          state_d      = (words_left_q == CNT_BITS'(1)) ? DONE : WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wrap_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      in_ready     <= (state_d == WAIT);
      mem_we       <= (state_d == WRITE);
      busy         <= (state_d == WAIT) || (state_d == WRITE);
      done         <= (state_d == DONE);
      wrap_err     <= wrap_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = ser_byte;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, self-checking bench for imem_loader with a byte-memory model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, mem_we, busy, done, wrap_err;
  logic [7:0]  mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_model [256];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .wrap_err   (wrap_err)
  );

  always #5 clk = ~clk;

  // Byte writes observed on the memory port.
  always @(negedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr] = mem_wdata;
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  base;
    logic [31:0] word;
    logic [31:0] addrs;
    logic [31:0] bytes;
    logic        wrap;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the word is accepted.
  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_word = w;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] fetch(input logic [7:0] pc);
    logic [7:0]  a;
    logic [31:0] r;
    a = pc; r = '0;
    for (int k = 0; k < 4; k++) begin
      r = {r[23:0], mem_model[a]};
      a = a + 8'd1;
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_wrap_err"}, 32'(wrap_err), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"},32'(mem_wdata),32'd0);
  endtask

  vec_t        tv [4];
  logic [31:0] bb [3];
  logic [14:0] pat;
  logic [31:0] w;
  int          idx;

  initial begin
    tv[0] = '{8'h10, 32'h12345678, 32'h10111213, 32'h12345678, 1'b0};
    tv[1] = '{8'hFE, 32'hDEADBEEF, 32'hFEFF0001, 32'hDEADBEEF, 1'b1};
    tv[2] = '{8'h80, 32'hCAFEF00D, 32'h80818283, 32'hCAFEF00D, 1'b0};
    tv[3] = '{8'hFB, 32'h11223344, 32'hFBFCFDFE, 32'h11223344, 1'b0};
    bb[0] = 32'hA0A1A2A3; bb[1] = 32'hB0B1B2B3; bb[2] = 32'hC0C1C2C3;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // in_valid outside WAIT is ignored
    in_valid = 1'b1; in_word = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_valid_writes", 32'(wr_addr.size()), 32'd0);
    check("idle_valid_ready", 32'(in_ready), 32'd0);

    // Single-word table
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      clear_log();
      do_start(tv[v].base, 8'd1);
      check($sformatf("v%0d_busy_wait", v), 32'(busy), 32'd1);
      send_word(tv[v].word);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_done", v), 32'(done), 32'd1);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_we_off", v), 32'(mem_we), 32'd0);
      check($sformatf("v%0d_wrap", v), 32'(wrap_err), 32'(tv[v].wrap));
      #1;
      check($sformatf("v%0d_nwr", v), 32'(wr_addr.size()), 32'd4);
      for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
        check($sformatf("v%0d_addr%0d", v, k), 32'(wr_addr[k]), 32'(tv[v].addrs[31-8*k -: 8]));
        check($sformatf("v%0d_data%0d", v, k), 32'(wr_data[k]), 32'(tv[v].bytes[31-8*k -: 8]));
      end
      check($sformatf("v%0d_fetch", v), fetch(tv[v].base), tv[v].bytes);
    end

    // Back-to-back three words, in_valid held high
    @(negedge clk);
    clear_log();
    do_start(8'h00, 8'd3);
    idx = 0; pat = '0; in_valid = 1'b1;
    for (int n = 0; n < 15; n++) begin
      in_word = bb[idx < 3 ? idx : 2];
      pat = {pat[13:0], in_ready};
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_ready_pattern", 32'(pat), 32'(15'b100001000010000));
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_busy", 32'(busy), 32'd0);
    #1;
    check("b2b_nwr", 32'(wr_addr.size()), 32'd12);
    for (int k = 0; k < 12 && k < wr_addr.size(); k++) begin
      w = bb[k/4];
      check($sformatf("b2b_addr%0d", k), 32'(wr_addr[k]), 32'(k));
      check($sformatf("b2b_data%0d", k), 32'(wr_data[k]), 32'(w[31-8*(k%4) -: 8]));
    end

    // Stall between words
    @(negedge clk);
    clear_log();
    do_start(8'h40, 8'd2);
    send_word(32'h0BADF00D);
    repeat (10) @(negedge clk);
    #1;
    check("stall_nwr", 32'(wr_addr.size()), 32'd4);
    check("stall_ready", 32'(in_ready), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    @(negedge clk);
    send_word(32'h600DCAFE);
    repeat (4) @(negedge clk);
    check("stall_done", 32'(done), 32'd1);
    #1;
    check("stall_nwr2", 32'(wr_addr.size()), 32'd8);
    if (wr_addr.size() == 8) begin
      check("stall_addr4", 32'(wr_addr[4]), 32'h44);
      check("stall_addr7", 32'(wr_addr[7]), 32'h47);
      check("stall_data4", 32'(wr_data[4]), 32'h60);
    end
    check("stall_fetch2", fetch(8'h44), 32'h600DCAFE);

    // Zero word count
    @(negedge clk);
    clear_log();
    do_start(8'h70, 8'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // start pulsed during WRITE is ignored
    @(negedge clk);
    clear_log();
    do_start(8'h20, 8'd1);
    send_word(32'h55AA33CC);
    start = 1'b1; base_addr = 8'h90; word_count = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("sdw_done", 32'(done), 32'd1);
    @(negedge clk);
    check("sdw_busy_after", 32'(busy), 32'd0);
    #1;
    check("sdw_nwr", 32'(wr_addr.size()), 32'd4);
    check("sdw_fetch", fetch(8'h20), 32'h55AA33CC);

    // Reset mid-word, then a clean reload
    @(negedge clk);
    clear_log();
    do_start(8'h30, 8'd2);
    send_word(32'h01234567);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_nwr", 32'(wr_addr.size()), 32'd2);
    @(negedge clk);
    clear_log();
    do_start(8'h50, 8'd1);
    send_word(32'h89ABCDEF);
    repeat (4) @(negedge clk);
    check("reload_done", 32'(done), 32'd1);
    #1;
    check("reload_nwr", 32'(wr_addr.size()), 32'd4);
    check("reload_fetch", fetch(8'h50), 32'h89ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
